// File: rtl/spi_cmd_regs.sv
// Byte-level command decoder and register bank behind spi_slave.
// Byte 0 of a frame is {write, addr[6:0]}; following bytes stream to/from addr, addr+1, ...
module spi_cmd_regs #(
  parameter int          NREGS     = 16,
  parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss,
  input  logic                 rx_done,
  input  logic [7:0]           rx_data,
  output logic [7:0]           tx_data,
  output logic [8*NREGS-1:0]   regs_flat,
  output logic                 wr_pulse,
  output logic [6:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [7:0] NREGS_B = 8'(NREGS);
  localparam logic [6:0] LAST    = 7'(NREGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR      = 3'd2,
    ST_RD      = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t      state_r, state_nx_s;
  logic        ss_meta_r, ss_sync_r;
  logic        fill_r, armed_r;
  logic        done_q_r;
  logic [6:0]  ptr_r, ptr_nx_s, ptr_inc_s;
  logic [7:0]  tx_r, tx_nx_s;
  logic        we_s;
  logic        ev_s;
  logic        cmd_oor_s;
  logic [7:0]  regs_r [NREGS];
  logic        wr_pulse_r;
  logic [6:0]  wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        busy_r;

  assign ev_s      = rx_done & ~done_q_r;
  assign ptr_inc_s = (ptr_r == LAST) ? 7'd0 : ptr_r + 7'd1;
  assign cmd_oor_s = ({1'b0, rx_data[6:0]} >= NREGS_B);

  // Input conditioning: ss synchroniser, rx_done edge history, re-arm tracking.
  // armed_r only sets once ss has genuinely been sampled high after reset, so a
  // frame cut by reset is ignored until ss toggles high and low again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_meta_r <= 1'b1;
      ss_sync_r <= 1'b1;
      fill_r    <= 1'b0;
      armed_r   <= 1'b0;
      done_q_r  <= 1'b0;
    end else begin
      ss_meta_r <= ss;
      ss_sync_r <= ss_meta_r;
      fill_r    <= 1'b1;
      armed_r   <= armed_r | (fill_r & ss_meta_r);
      done_q_r  <= rx_done;
    end
  end

  // Next-state, pointer and transmit byte decode.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    tx_nx_s    = tx_r;
    we_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_nx_s  = IDLE_BYTE;
        ptr_nx_s = 7'd0;
        if (armed_r && !ss_sync_r) begin
          state_nx_s = ST_CMD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ev_s) begin
          if (cmd_oor_s) begin
            state_nx_s = ST_DISCARD;
            tx_nx_s    = 8'h00;
          end else if (rx_data[7]) begin
            state_nx_s = ST_WR;
            ptr_nx_s   = rx_data[6:0];
          end else begin
            state_nx_s = ST_RD;
            ptr_nx_s   = rx_data[6:0];
            tx_nx_s    = regs_r[rx_data[AW-1:0]];
          end
        end else begin
          state_nx_s = ST_CMD;
        end
      end
      ST_WR: begin
        if (ev_s) begin
          we_s     = 1'b1;
          ptr_nx_s = ptr_inc_s;
        end else begin
          ptr_nx_s = ptr_r;
        end
      end
      ST_RD: begin
        if (ev_s) begin
          ptr_nx_s = ptr_inc_s;
          tx_nx_s  = regs_r[ptr_inc_s[AW-1:0]];
        end else begin
          ptr_nx_s = ptr_r;
        end
      end
      ST_DISCARD: begin
        tx_nx_s = 8'h00;
      end
      default: begin
        state_nx_s = ST_IDLE;
        tx_nx_s    = IDLE_BYTE;
        ptr_nx_s   = 7'd0;
      end
    endcase
    // Frame end wins over the decode above, but a same-cycle write still commits.
    if (state_r != ST_IDLE && ss_sync_r) begin
      state_nx_s = ST_IDLE;
      tx_nx_s    = IDLE_BYTE;
      ptr_nx_s   = 7'd0;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // FSM state, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 7'd0;
      tx_r       <= IDLE_BYTE;
      busy_r     <= 1'b0;
      wr_pulse_r <= 1'b0;
      wr_addr_r  <= 7'd0;
      wr_data_r  <= 8'h00;
    end else begin
      state_r    <= state_nx_s;
      ptr_r      <= ptr_nx_s;
      tx_r       <= tx_nx_s;
      busy_r     <= (state_nx_s != ST_IDLE);
      wr_pulse_r <= we_s;
      if (we_s) begin
        wr_addr_r <= ptr_r;
        wr_data_r <= rx_data;
      end
    end
  end

  // Register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (we_s) begin
      regs_r[ptr_r[AW-1:0]] <= rx_data;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_r[g];
  end

  assign tx_data  = tx_r;
  assign busy     = busy_r;
  assign wr_pulse = wr_pulse_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Directed self-checking bench for spi_cmd_regs (NREGS=16, IDLE_BYTE=8'hA5).
module tb_spi_cmd_regs;

  logic         clk;
  logic         rst;
  logic         ss;
  logic         rx_done;
  logic [7:0]   rx_data;
  logic [7:0]   tx_data;
  logic [127:0] regs_flat;
  logic         wr_pulse;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         busy;

  int           total;
  int           passed;
  int           pulse_cnt;
  logic [7:0]   exp_regs [16];

  spi_cmd_regs #(.NREGS(16), .IDLE_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  function automatic logic [127:0] packed_exp();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ss_set(input logic v);
    @(negedge clk);
    ss = v;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    total = 0; passed = 0; pulse_cnt = 0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    rst = 1'b0; ss = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    check("rst_tx", 128'(tx_data), 128'(8'hA5));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_regs", regs_flat, 128'd0);
    check("rst_wr", {wr_pulse, wr_addr, wr_data}, 128'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Write burst 0x83, 0x11, 0x22
    ss_set(1'b0);
    check("wr_busy", 128'(busy), 128'(1'b1));
    send_byte(8'h83, 1);
    send_byte(8'h11, 1);
    check("wr1_pulses", 128'(pulse_cnt), 128'(1));
    check("wr1_addr_data", {wr_addr, wr_data}, {7'd3, 8'h11});
    send_byte(8'h22, 1);
    check("wr2_pulses", 128'(pulse_cnt), 128'(2));
    check("wr2_addr_data", {wr_addr, wr_data}, {7'd4, 8'h22});
    ss_set(1'b1);
    exp_regs[3] = 8'h11; exp_regs[4] = 8'h22;
    check("wr_regs", regs_flat, packed_exp());
    check("wr_idle_busy", 128'(busy), 128'(1'b0));

    // Read burst 0x03, 0x00, 0x00
    ss_set(1'b0);
    check("rd_tx_pre", 128'(tx_data), 128'(8'hA5));
    send_byte(8'h03, 1);
    check("rd_tx_r3", 128'(tx_data), 128'(8'h11));
    send_byte(8'h00, 1);
    check("rd_tx_r4", 128'(tx_data), 128'(8'h22));
    send_byte(8'h00, 1);
    check("rd_no_pulse", 128'(pulse_cnt), 128'(2));
    ss_set(1'b1);
    check("rd_tx_post", 128'(tx_data), 128'(8'hA5));

    // Wrap: 0x8F, 0xAA, 0xBB
    ss_set(1'b0);
    send_byte(8'h8F, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    ss_set(1'b1);
    exp_regs[15] = 8'hAA; exp_regs[0] = 8'hBB;
    check("wrap_regs", regs_flat, packed_exp());
    check("wrap_addr_data", {wr_addr, wr_data}, {7'd0, 8'hBB});
    ss_set(1'b0);
    send_byte(8'h0F, 1);
    check("wrap_rd15", 128'(tx_data), 128'(8'hAA));
    send_byte(8'h00, 1);
    check("wrap_rd0", 128'(tx_data), 128'(8'hBB));
    ss_set(1'b1);

    // Out-of-range command
    ss_set(1'b0);
    send_byte(8'h90, 1);
    check("oor_tx", 128'(tx_data), 128'(8'h00));
    send_byte(8'h55, 1);
    check("oor_tx2", 128'(tx_data), 128'(8'h00));
    check("oor_busy", 128'(busy), 128'(1'b1));
    ss_set(1'b1);
    check("oor_pulses", 128'(pulse_cnt), 128'(4));
    check("oor_regs", regs_flat, packed_exp());

    // rx_done held high 5 cycles
    ss_set(1'b0);
    send_byte(8'h81, 1);
    send_byte(8'h77, 5);
    check("lvl_pulses", 128'(pulse_cnt), 128'(5));
    ss_set(1'b1);
    exp_regs[1] = 8'h77;
    check("lvl_regs", regs_flat, packed_exp());

    // Abort after command byte, then read reg5
    ss_set(1'b0);
    send_byte(8'h85, 1);
    ss_set(1'b1);
    check("abort_pulses", 128'(pulse_cnt), 128'(5));
    ss_set(1'b0);
    send_byte(8'h05, 1);
    check("abort_rd5", 128'(tx_data), 128'(8'h00));
    ss_set(1'b1);

    // Reset mid-write-frame
    ss_set(1'b0);
    send_byte(8'h82, 1);
    send_byte(8'h44, 1);
    check("mrst_pre_pulses", 128'(pulse_cnt), 128'(6));
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    check("mrst_regs", regs_flat, 128'd0);
    check("mrst_busy", 128'(busy), 128'(1'b0));
    check("mrst_tx", 128'(tx_data), 128'(8'hA5));
    check("mrst_wr", {wr_addr, wr_data}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h83, 1);
    send_byte(8'h99, 1);
    check("mrst_ign_pulses", 128'(pulse_cnt), 128'(6));
    check("mrst_ign_busy", 128'(busy), 128'(1'b0));
    check("mrst_ign_regs", regs_flat, 128'd0);
    ss_set(1'b1);
    ss_set(1'b0);
    check("rearm_busy", 128'(busy), 128'(1'b1));
    send_byte(8'h86, 1);
    send_byte(8'h12, 1);
    ss_set(1'b1);
    exp_regs[6] = 8'h12;
    check("rearm_regs", regs_flat, packed_exp());
    check("rearm_addr_data", {wr_addr, wr_data}, {7'd6, 8'h12});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_cmd_regs.md
Name: spi_cmd_regs

Overview:
- Byte-level command decoder and register bank sitting directly downstream of spi_slave.
- Consumes the slave's received byte (dout) and its done indication.
- Drives the slave's transmit byte (din), giving an SPI master read/write access to NREGS 8-bit registers.
- Register contents are exported to the rest of the design, together with a write strobe.

Parameters:
- NREGS, 16, number of 8-bit registers; legal range 2..128.
- IDLE_BYTE, 8'hA5, value presented on tx_data while the command byte is being shifted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- ss  in  1  SPI slave select pin, active low; asynchronous to clk.
- rx_done  in  1  spi_slave done; high level for one or more cycles per received byte.
- rx_data  in  8  spi_slave dout; stable while rx_done is high.
- tx_data  out  8  to spi_slave din; byte shifted out during the next SPI byte.
- regs_flat  out  8*NREGS  register contents; reg[i] = regs_flat[8*i+7:8*i].
- wr_pulse  out  1  one-cycle strobe when a register is written from SPI.
- wr_addr  out  7  address of the last write.
- wr_data  out  8  data of the last write.
- busy  out  1  high while a frame is in progress (synchronised ss low).

Behaviour:
- Reset (rst=0, async) values:
  - all registers 0; tx_data = IDLE_BYTE; wr_pulse = 0; wr_addr = 0; wr_data = 0; busy = 0.
  - FSM = IDLE; ss sync flops = 1; rx_done history flop = 0.
- Input conditioning:
  - ss passes through a 2-flop synchroniser (ss_s). Frame start = ss_s falling; frame end = ss_s rising.
  - Byte event: a single-cycle internal pulse on each rising edge of rx_done (registered history). A level held high for N cycles yields exactly one event.
  - rx_data is sampled in the event cycle.
- Frame protocol:
  - Byte 0 = command: bit7 = 1 write, 0 read; bits[6:0] = start address A.
  - Following bytes access A, A+1, …; the address wraps from NREGS-1 to 0.
- FSM states: IDLE, CMD, WR, RD, DISCARD.
  - IDLE: busy=0; tx_data=IDLE_BYTE. On ss_s=0 → CMD.
  - CMD, on byte event:
    - A >= NREGS → DISCARD, tx_data=8'h00.
    - bit7=1 → WR, ptr=A.
    - bit7=0 → RD, ptr=A, tx_data=reg[A] on the next clock (≤1 cycle after the event).
  - WR, on byte event:
    - reg[ptr] ← rx_data.
    - wr_pulse=1 for exactly that following cycle; wr_addr=ptr, wr_data=rx_data (held until the next write).
    - ptr advances with wrap.
  - RD, on byte event: ptr advances with wrap; tx_data ← reg[new ptr] on the next clock. Received data is ignored.
  - DISCARD: all byte events ignored; tx_data=8'h00.
  - Any state except IDLE: ss_s=1 → IDLE, tx_data=IDLE_BYTE, ptr state cleared.
- busy = 1 in every state except IDLE.
- Simultaneous events:
  - A byte event in the same cycle as ss_s rising is processed first (a write still commits); the FSM then enters IDLE.
  - ss_s falling and a byte event in the same cycle: the byte is ignored, because events are acted on only in CMD/WR/RD.
- Aborts and reset:
  - A frame aborted mid-stream commits only the bytes whose events already occurred. The next frame restarts in CMD.
  - Reset mid-frame returns everything to reset values immediately. The remainder of the frame is ignored until ss_s goes high and then low again.
- Register values are readable in the same frame they were written: tx_data uses the updated array.

Test Plan:
- Write burst: ss low; bytes 0x83, 0x11, 0x22; ss high → reg3=0x11, reg4=0x22. wr_pulse fires twice: (addr3, 0x11), then (addr4, 0x22). Other registers stay 0.
- Read burst after the write: bytes 0x03, 0x00, 0x00 → tx_data = 0xA5 before the cmd byte, 0x11 after the cmd event, 0x22 after the second event. No wr_pulse.
- Wrap (NREGS=16): bytes 0x8F, 0xAA, 0xBB → reg15=0xAA, reg0=0xBB. A read with 0x0F returns 0xAA, then 0xBB.
- Out-of-range and done-level robustness:
  - Cmd 0x90, then 0x55 → no writes; tx_data=0x00.
  - rx_done held high 5 cycles on a write byte → exactly one wr_pulse.
- Abort and reset:
  - ss high after the cmd byte 0x85 → no write; the next frame 0x05 reads reg5=0x00.
  - rst=0 during a write frame → regs_flat all 0, busy=0; later bytes in that frame are ignored.
